// File: rtl/sweep_checker.sv
// sweep_checker: applies every N_IN-bit vector to a combinational DUT and compares its output
// against a latched truth table. Defining SWEEP_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module sweep_checker #(
   parameter int N_IN   = 4,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   expected,
   input  logic                 dut_x,
   output logic [N_IN-1:0]      dut_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_count,
   output logic [N_IN-1:0]      first_err,
   output logic [2:0]           state_dbg
);

   localparam logic [N_IN-1:0] LAST_IDX  = {N_IN{1'b1}};
   localparam logic [N_IN:0]   ERR_MAX   = {(N_IN+1){1'b1}};
   localparam logic [3:0]      WAIT_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRIVE = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      END   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [N_IN-1:0]       idx_q, idx_d;
   logic [3:0]            wait_q, wait_d;
   logic [2**N_IN-1:0]    table_q, table_d;
   logic [N_IN:0]         err_q, err_d;
   logic [N_IN-1:0]       first_q, first_d;
   logic                  pass_q, pass_d;
   logic                  done_q, done_d;
   logic                  mismatch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         wait_q  <= '0;
         table_q <= '0;
         err_q   <= '0;
         first_q <= '0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         table_q <= table_d;
         err_q   <= err_d;
         first_q <= first_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
      end
   end

   assign mismatch = (dut_x != table_q[idx_q]);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      table_d = table_q;
      err_d   = err_q;
      first_d = first_q;
      pass_d  = pass_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               table_d = expected;
               err_d   = '0;
               first_d = '0;
               pass_d  = 1'b0;
               idx_d   = '0;
               state_d = DRIVE;
            end
         end

         DRIVE: begin
            wait_d  = '0;
            state_d = (SETTLE == 0) ? CHECK : WAIT;
         end

         WAIT: begin
            if (wait_q == WAIT_LAST) begin
               state_d = CHECK;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end

         CHECK: begin
            // first_err is captured only on the transition of the count away from zero
            if (mismatch) begin
               if (err_q == '0) begin
                  first_d = idx_q;
               end
               if (err_q != ERR_MAX) begin
                  err_d = err_q + (N_IN+1)'(1);
               end
            end
`ifdef SWEEP_STOP_ON_ERR_EN
            if (mismatch || (idx_q == LAST_IDX)) begin
               state_d = END;
            end else begin
               idx_d   = idx_q + N_IN'(1);
               state_d = DRIVE;
            end
`else
            if (idx_q == LAST_IDX) begin
               state_d = END;
            end else begin
               idx_d   = idx_q + N_IN'(1);
               state_d = DRIVE;
            end
`endif
         end

         END: begin
            done_d  = 1'b1;
            pass_d  = (err_q == '0);
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // dut_in is the vector index itself, so it naturally holds through WAIT/CHECK and in IDLE
   assign dut_in    = idx_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign first_err = first_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_sweep_checker.sv
// Bench for sweep_checker: table of truth-table sweeps plus hand sequences for
// restart attempts, mid-sweep reset and a SETTLE=0 / N_IN=2 instance.
module tb_sweep_checker;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] expected;
   logic        dut_x;
   logic [3:0]  dut_in;
   logic        busy;
   logic        done;
   logic        pass;
   logic [4:0]  err_count;
   logic [3:0]  first_err;
   logic [2:0]  state_dbg;

   logic        start2;
   logic [3:0]  expected2;
   logic        dut_x2;
   logic [1:0]  dut_in2;
   logic        busy2;
   logic        done2;
   logic        pass2;
   logic [2:0]  err_count2;
   logic [1:0]  first_err2;
   logic [2:0]  state_dbg2;

   int dmode;
   int cyc;
   int total;
   int bad;

   logic [17:0] exp_q[$];
   int          start_q[$];

   typedef struct {
      logic [15:0] tbl;
      int          mode;
      int          err;
      int          first;
      bit          pas;
      bit          disturb;
   } vec_t;

   vec_t vecs[9];

   sweep_checker #(.N_IN(4), .SETTLE(1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .expected  (expected),
      .dut_x     (dut_x),
      .dut_in    (dut_in),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .first_err (first_err),
      .state_dbg (state_dbg)
   );

   sweep_checker #(.N_IN(2), .SETTLE(0)) u_dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start2),
      .expected  (expected2),
      .dut_x     (dut_x2),
      .dut_in    (dut_in2),
      .busy      (busy2),
      .done      (done2),
      .pass      (pass2),
      .err_count (err_count2),
      .first_err (first_err2),
      .state_dbg (state_dbg2)
   );

   // modelled DUT: 0 = parity of the vector, 1 = stuck at 0, 2 = stuck at 1
   assign dut_x  = (dmode == 0) ? ^dut_in : (dmode == 2);
   assign dut_x2 = ^dut_in2;

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit stop_mode();
`ifdef SWEEP_STOP_ON_ERR_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model(input logic [15:0] tbl, input int mode,
                        output int e_err, output int e_first, output bit e_pass);
      bit         halted;
      logic [3:0] k4;
      logic       x;
      e_err   = 0;
      e_first = 0;
      halted  = 1'b0;
      for (int k = 0; k < 16; k++) begin
         k4 = 4'(k);
         x  = (mode == 0) ? ^k4 : (mode == 2);
         if (!halted && (x != tbl[k])) begin
            if (e_err == 0) e_first = k;
            e_err++;
            if (stop_mode()) halted = 1'b1;
         end
      end
      e_pass = (e_err == 0);
   endtask

   // scoreboard: pops a result record on every done pulse
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            logic [17:0] rec;
            int          acc;
            rec = exp_q.pop_front();
            acc = start_q.pop_front();
            chk("err_count", int'(err_count), int'(rec[8:4]));
            chk("first_err", int'(first_err), int'(rec[3:0]));
            chk("pass", int'(pass), int'(rec[9]));
            chk("latency", cyc - acc, int'(rec[17:10]));
         end
      end
   end

   // driver: one full sweep on the N_IN=4 instance
   task automatic run_sweep(input logic [15:0] tbl, input int mode, input int e_err,
                            input int e_first, input bit e_pass, input bit disturb);
      int lat;
      int last;
      int seq_bad;
      int w;
      int vi;
      lat  = (stop_mode() && e_err > 0) ? (e_first + 1) * 3 + 1 : 49;
      last = (lat - 2) / 3;
      @(negedge clk);
      expected = tbl;
      dmode    = mode;
      start    = 1'b1;
      exp_q.push_back({8'(lat), e_pass, 5'(e_err), 4'(e_first)});
      start_q.push_back(cyc + 1);
      @(negedge clk);
      start   = 1'b0;
      seq_bad = 0;
      for (int t = 0; t < lat; t++) begin
         vi = (t / 3 > last) ? last : t / 3;
         if (!busy || int'(dut_in) != vi || done) begin
            if (seq_bad == 0) $display("FAIL vec_seq t=%0d act=%0d exp=%0d busy=%0d", t, dut_in, vi, busy);
            seq_bad++;
         end
         if (disturb && t == 9) begin
            start    = 1'b1;
            expected = ~tbl;
         end
         if (disturb && t == 10) start = 1'b0;
         if (disturb && t == lat - 1) start = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;
      chk("vec_seq_errors", seq_bad, 0);
      w = 0;
      while (!done && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("done_seen", int'(done), 1);
      if (!done) begin
         exp_q.delete();
         start_q.delete();
      end
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      chk("idle_after", int'(busy), 0);
      chk("err_hold", int'(err_count), e_err);
      chk("dut_in_hold", int'(dut_in), last);
   endtask

   initial begin
      int e_err, e_first, w;
      bit e_pass;
      logic [15:0] rt;

      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      expected  = 16'h0;
      dmode     = 0;
      start2    = 1'b0;
      expected2 = 4'h0;

      vecs[0] = '{16'h6996, 0, 0, 0, 1'b1, 1'b0};
      vecs[1] = '{16'h6996, 1, 8, 1, 1'b0, 1'b0};
      vecs[2] = '{16'h6996, 2, 8, 0, 1'b0, 1'b0};
      vecs[3] = '{16'hFFFF, 2, 0, 0, 1'b1, 1'b0};
      vecs[4] = '{16'h0000, 2, 16, 0, 1'b0, 1'b0};
      vecs[5] = '{16'h6997, 0, 1, 0, 1'b0, 1'b0};
      vecs[6] = '{16'hE996, 0, 1, 15, 1'b0, 1'b0};
      vecs[7] = '{16'h0000, 0, 8, 1, 1'b0, 1'b0};
      vecs[8] = '{16'h6996, 0, 0, 0, 1'b1, 1'b1};

      #2;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pass", int'(pass), 0);
      chk("rst_err", int'(err_count), 0);
      chk("rst_first", int'(first_err), 0);
      chk("rst_dut_in", int'(dut_in), 0);
      chk("rst_state", int'(state_dbg), 0);
      chk("rst_busy2", int'(busy2), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_no_start", int'(busy), 0);

      for (int i = 0; i < 9; i++) begin
         e_err = vecs[i].err;
         if (stop_mode() && e_err > 0) e_err = 1;
         run_sweep(vecs[i].tbl, vecs[i].mode, e_err, vecs[i].first, vecs[i].pas, vecs[i].disturb);
      end

      for (int i = 0; i < 4; i++) begin
         rt = 16'($urandom_range(0, 65535));
         model(rt, 0, e_err, e_first, e_pass);
         run_sweep(rt, 0, e_err, e_first, e_pass, 1'b0);
      end

      // abort a sweep with an asynchronous reset at vector 7
      @(negedge clk);
      expected = 16'h6996;
      dmode    = 0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (dut_in != 4'd7 && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("reach_vec7", int'(dut_in), 7);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_dut_in", int'(dut_in), 0);
      chk("abort_state", int'(state_dbg), 0);
      repeat (3) @(negedge clk);
      chk("abort_no_done", int'(done), 0);
      rst_n = 1'b1;
      @(negedge clk);
      run_sweep(16'h6996, 0, 0, 0, 1'b1, 1'b0);

      // SETTLE=0, N_IN=2 instance: 2 cycles per vector
      for (int pass_i = 0; pass_i < 2; pass_i++) begin
         int l2, err2, first2, seq_bad2, vi2;
         bit pass2_e;
         if (pass_i == 0) begin
            expected2 = 4'b0110;
            err2 = 0; first2 = 0; pass2_e = 1'b1; l2 = 9;
         end else begin
            expected2 = 4'b0000;
            err2 = stop_mode() ? 1 : 2; first2 = 1; pass2_e = 1'b0;
            l2 = stop_mode() ? 5 : 9;
         end
         @(negedge clk);
         start2 = 1'b1;
         @(negedge clk);
         start2   = 1'b0;
         seq_bad2 = 0;
         for (int t = 0; t < l2; t++) begin
            vi2 = (t / 2 > (l2 - 2) / 2) ? (l2 - 2) / 2 : t / 2;
            if (!busy2 || int'(dut_in2) != vi2 || done2) seq_bad2++;
            @(negedge clk);
         end
         chk("s0_vec_seq_errors", seq_bad2, 0);
         chk("s0_done_at_latency", int'(done2), 1);
         chk("s0_err", int'(err_count2), err2);
         chk("s0_first", int'(first_err2), first2);
         chk("s0_pass", int'(pass2), int'(pass2_e));
         @(negedge clk);
      end

      repeat (2) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sweep_checker.md
SWEEP_CHECKER -- requirements
Module: sweep_checker

Interface
REQ-001 The parameter list SHALL be: N_IN, default 4, number of DUT input bits driven (range 1..8).
REQ-002 The parameter list SHALL be: SETTLE, default 1, clock cycles between driving a vector and sampling the response (range 0..15).
REQ-003 The module SHALL have a single clock domain: clk  input  1  rising-edge clock.
REQ-004 The reset port SHALL be: rst_n  input  1  asynchronous active-low reset.
REQ-005 The port start  input  1 SHALL mean: a one-cycle request to begin a sweep.
REQ-006 The port expected  input  2**N_IN SHALL carry the expected truth table, with bit k being the expected output for input vector k.
REQ-007 The port dut_x  input  1 SHALL carry the DUT output under test.
REQ-008 The port dut_in  output  N_IN SHALL carry the vector currently applied to the DUT.
REQ-009 The port busy  output  1 SHALL be high while a sweep is in progress.
REQ-010 The port done  output  1 SHALL carry a one-cycle pulse at the end of a sweep.
REQ-011 The port pass  output  1 SHALL be high when the last completed sweep had zero mismatches.
REQ-012 The port err_count  output  N_IN+1 SHALL carry the mismatch count of the current or last sweep.
REQ-013 The port first_err  output  N_IN SHALL carry the index of the first mismatching vector, or 0 if there was none.

Function
REQ-014 The FSM SHALL have the states IDLE, DRIVE, WAIT, CHECK and END.
REQ-015 In IDLE, start=1 SHALL latch expected, clear err_count, first_err and pass, set the vector index to 0, and move to DRIVE.
REQ-016 In DRIVE, dut_in SHALL equal the index for exactly 1 cycle, after which the FSM goes to WAIT, or to CHECK when SETTLE=0.
REQ-017 In WAIT, the FSM SHALL hold dut_in for SETTLE cycles and then go to CHECK.
REQ-018 In CHECK, the FSM SHALL compare dut_x against the latched expected[index]; on mismatch it increments err_count and, if this is the first mismatch, loads first_err=index.
REQ-019 From CHECK, if index = 2**N_IN-1 the FSM SHALL go to END; otherwise it increments the index and goes to DRIVE.
REQ-020 dut_in SHALL remain stable from DRIVE through CHECK of the same vector, giving SETTLE+2 cycles per vector.
REQ-021 In END, the block SHALL assert done for 1 cycle, set pass = (err_count==0), and return to IDLE.
REQ-022 Total latency from the start-accepting edge to done high SHALL be 2**N_IN*(SETTLE+2)+1 cycles.
REQ-023 busy SHALL be high in DRIVE, WAIT, CHECK and END, and low in IDLE.
REQ-024 start SHALL be ignored while busy=1, and the latched expected SHALL be unaffected by later changes to the port.
REQ-025 start asserted in the same cycle as END SHALL be ignored; a new sweep begins only when start is sampled in IDLE.
REQ-026 err_count SHALL be wide enough for 2**N_IN mismatches and SHALL never wrap.
REQ-027 pass, err_count and first_err SHALL hold their values in IDLE until the next accepted start.
REQ-028 dut_in SHALL hold its last vector in IDLE.

Reset
REQ-029 While rst_n=0, the FSM SHALL be forced to IDLE immediately, regardless of clk.
REQ-030 Reset values SHALL be: dut_in=0, busy=0, done=0, pass=0, err_count=0, first_err=0, index=0, latched table=0.
REQ-031 A reset in the middle of a sweep SHALL abort it with no done pulse; after rst_n rises, the next start begins from vector 0.

Configuration
REQ-032 When the macro SWEEP_STOP_ON_ERR_EN is defined, the FSM SHALL go from CHECK directly to END on the first mismatch, giving err_count=1, pass=0 and first_err = the failing index.
REQ-033 When SWEEP_STOP_ON_ERR_EN is undefined, all 2**N_IN vectors SHALL always be checked.

Verification
REQ-034 With N_IN=4, SETTLE=1, expected=16'h6996 and dut_x = XOR of dut_in, a start pulse SHALL give done at cycle 49, pass=1, err_count=0, first_err=0.
REQ-035 With the same table and dut_x forced to 0, the sweep SHALL end with pass=0, err_count=8, first_err=1.
REQ-036 With SWEEP_STOP_ON_ERR_EN defined and dut_x forced to 0, the sweep SHALL end with done after vector 1, err_count=1, first_err=1.
REQ-037 Asserting rst_n=0 at vector 7 SHALL drive busy=0 and dut_in=0 asynchronously with no done; a subsequent start SHALL show dut_in starting at 0.
REQ-038 A second start pulse at vector 3, plus expected changed mid-sweep, SHALL not restart the sweep or alter the result versus the first scenario.
REQ-039 With SETTLE=0 and N_IN=2, the spacing between vectors SHALL be 2 cycles and the latency SHALL be 9 cycles.
